bpsk_ber_tester: RTL and testbench
==================================

# bpsk_ber_tester

Synthesizable PRBS bit-error-rate tester for the BPSK modem. It drives `bpsk_modem_top` with a PRBS bit stream through `bit_data_in`/`bit_data_in_en`, and self-synchronises a checker to `bit_data_out` regardless of modem latency. It reports lock state, bit and error counts. It is the on-chip, parametrised successor to the toggling-bit loopback stimulus, generalised in PRBS order, bit rate and counter width, and adds lock/loss detection and error accounting.

## Interface
Parameters:
- `PRBS_ORDER`, 7 — LFSR order; 7 (x^7+x^6+1) or 15 (x^15+x^14+1) only, other values are illegal.
- `SYMBOL_CYCLES`, 20 — clk cycles per bit; ≥ 2.
- `RX_SAMPLE_OFFSET`, 10 — cycles after each tx strobe at which `rx_bit` is sampled; 0..SYMBOL_CYCLES-1.
- `LOCK_BITS`, 32 — consecutive matches needed to lock; also the loss-detection window length, in bits.
- `LOSS_ERRS`, 8 — errors within one window that declare loss of lock.
- `CNT_W`, 32 — width of the bit and error counters.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle pulse; clears counters and begins a run.
- `stop` in 1 — one-cycle pulse; ends the run and holds the counters.
- `tx_bit` out 1 — connects to modem `bit_data_in`; held stable between strobes.
- `tx_bit_en` out 1 — connects to `bit_data_in_en`; one-cycle strobe per bit.
- `rx_bit` in 1 — from modem `bit_data_out`.
- `locked` out 1 — checker is in LOCKED.
- `lock_lost` out 1 — sticky; set on loss of lock, cleared by `start` or `rst`.
- `bit_count` out CNT_W — bits checked while LOCKED.
- `err_count` out CNT_W — mismatches while LOCKED.

## Operation
- States: IDLE, SEED, CHECK, LOCKED.
- IDLE:
  - tx_bit_en = 0 and the bit timer is stopped.
  - On `start`, reseed the tx LFSR to all ones, clear the counters and `lock_lost`, then go to SEED.
- Bit timer:
  - Runs in every state except IDLE and wraps at SYMBOL_CYCLES-1.
  - tx strobe at count 0: shift the tx LFSR, drive its new output on tx_bit, pulse tx_bit_en.
  - rx strobe at count RX_SAMPLE_OFFSET.
- SEED:
  - Each rx strobe shifts rx_bit into the predictor LFSR.
  - After PRBS_ORDER strobes, go to CHECK with the match counter at 0.
- CHECK:
  - Each rx strobe compares rx_bit with the predictor output, then advances the predictor.
  - Match: increment the match counter; on reaching LOCK_BITS, go to LOCKED.
  - Mismatch: go back to SEED.
- LOCKED:
  - Each rx strobe increments bit_count; a mismatch increments err_count and the window error counter.
  - The window error counter resets every LOCK_BITS bits.
  - When the window error counter reaches LOSS_ERRS: set lock_lost, go to SEED, keep bit_count and err_count.
- Counters saturate at all ones and never wrap.
- `stop` in any state: go to IDLE and hold all counters and flags.
- `start` and `stop` in the same cycle: start wins.
- `start` while running: full restart, same as from IDLE.
- The predictor LFSR is never left all-zero. An all-zero seed, caused by a stuck-at-0 channel, forces a return to SEED at the next check.

## Timing
- Reset values:
  - Outputs: tx_bit 0, tx_bit_en 0, locked 0, lock_lost 0, bit_count 0, err_count 0.
  - Internal: state IDLE, timers 0.
- All outputs are registered.
- `start` sampled at edge N:
  - State is SEED from N+1.
  - First tx_bit_en pulse in cycle N+1.
  - First rx strobe in cycle N+1+RX_SAMPLE_OFFSET.
- `locked` rises in the cycle after the LOCK_BITS-th consecutive matching rx strobe, and falls in the cycle after the loss decision or `stop`.
- Counter updates are visible one cycle after their rx strobe.
- `rst` mid-run returns every output to its reset value on the next edge.

## Configuration
- `BER_ERR_INJECT_EN` defined:
  - Adds input port `inject_err` (1 bit).
  - A pulse arms a flag that inverts exactly the next transmitted bit; the flag clears at that tx strobe.
  - Further pulses while armed are ignored.
- Not defined: the port is absent and tx_bit is always the pure PRBS.

## Structure
- Package `bpsk_ber_pkg` holds:
  - the state enum;
  - the tap constants for orders 7 and 15;
  - a function returning the feedback taps for a given order.
- Sub-module `prbs_lfsr`, parametrised by order, with load (serial seed), advance, and output. It is instantiated twice: tx generator and rx predictor.

## Test plan
- Zero-delay wire loopback tx_bit→rx_bit, defaults:
  - locked rises after 7 + 32 bits;
  - after 1000 further bits, bit_count = 1000 and err_count = 0.
- Modem loopback through `bpsk_modem_top` with SYMBOL_CYCLES = 20 → lock achieved and err_count = 0 over 500 bits.
- `BER_ERR_INJECT_EN`, inject_err pulsed 5 times spaced 100 bits apart while locked → err_count = 5 and locked stays 1.
- Channel inverted (rx = ~tx) → never locks; locked = 0 and bit_count = 0 after 200 bits.
- Locked, then rx forced to random data for 32 bits (≥ 8 errors) → lock_lost = 1, state SEED, counts held.
- CNT_W = 4, wire loopback → bit_count saturates at 15.
- rst asserted mid-run → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/bpsk_ber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_ber_pkg
// Description : Shared types and PRBS tap constants for the BPSK BER tester.
// Revision    : 1.0 - initial release
// ============================================================================
package bpsk_ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } ber_state_t;

    localparam int c_TAPS_W = 15;

    // Feedback masks over the shift register, bit 0 holding the newest bit.
    localparam logic [c_TAPS_W-1:0] c_TAPS_7  = 15'h0060;  // x^7  + x^6  + 1
    localparam logic [c_TAPS_W-1:0] c_TAPS_15 = 15'h6000;  // x^15 + x^14 + 1

    function automatic logic [c_TAPS_W-1:0] prbs_taps(input int order);
        case (order)
            7:       return c_TAPS_7;
            15:      return c_TAPS_15;
            default: return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : prbs_lfsr
// Description : Fibonacci PRBS LFSR with all-ones init, serial load and advance.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr
    import bpsk_ber_pkg::*;
#(
    parameter int ORDER = 7
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_init,
    input  logic i_load,
    input  logic i_load_bit,
    input  logic i_adv,
    output logic o_next,
    output logic o_zero
);

    localparam logic [c_TAPS_W-1:0] c_TAPS_ALL = prbs_taps(ORDER);
    localparam logic [ORDER-1:0]    c_TAPS     = c_TAPS_ALL[ORDER-1:0];

    logic [ORDER-1:0] r_state;
    logic [ORDER-1:0] w_base;

    // Init and advance may coincide: the shift then starts from the all-ones seed.
    assign w_base = i_init ? '1 : r_state;
    assign o_next = ^(w_base & c_TAPS);
    assign o_zero = (r_state == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '1;
        end else if (i_load) begin
            r_state <= {w_base[ORDER-2:0], i_load_bit};
        end else if (i_adv) begin
            r_state <= {w_base[ORDER-2:0], o_next};
        end else if (i_init) begin
            r_state <= '1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpsk_ber_tester.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_ber_tester
// Description : PRBS BER tester with self-synchronising checker for the BPSK
//               modem. Optional macro BER_ERR_INJECT_EN adds inject_err.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_ber_tester
    import bpsk_ber_pkg::*;
#(
    parameter int PRBS_ORDER       = 7,
    parameter int SYMBOL_CYCLES    = 20,
    parameter int RX_SAMPLE_OFFSET = 10,
    parameter int LOCK_BITS        = 32,
    parameter int LOSS_ERRS        = 8,
    parameter int CNT_W            = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             tx_bit,
    output logic             tx_bit_en,
    input  logic             rx_bit,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
`ifdef BER_ERR_INJECT_EN
    ,
    input  logic             inject_err
`endif
);

    localparam int c_TMR_W   = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam int c_SEED_W  = $clog2(PRBS_ORDER);
    localparam int c_MATCH_W = (LOCK_BITS > 1) ? $clog2(LOCK_BITS) : 1;
    localparam int c_WERR_W  = $clog2(LOSS_ERRS + 1);

    ber_state_t           r_state;
    ber_state_t           w_state_nxt;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [c_SEED_W-1:0]  r_seed_cnt;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_MATCH_W-1:0] r_win_bits;
    logic [c_WERR_W-1:0]  r_win_err;
    logic [c_WERR_W-1:0]  w_win_err_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     r_err_cnt;
    logic                 r_tx_bit;
    logic                 r_tx_en;
    logic                 r_locked;
    logic                 r_lock_lost;

    logic w_running, w_tx_stb, w_rx_stb, w_seed_load, w_pred_adv, w_lk_stb;
    logic w_tx_next, w_tx_zero, w_tx_init, w_pred_next, w_pred_zero;
    logic w_mm, w_loss, w_flip;

    assign w_mm          = rx_bit ^ w_pred_next;
    assign w_win_err_nxt = r_win_err + c_WERR_W'(w_mm);
    assign w_loss        = (w_win_err_nxt == c_WERR_W'(LOSS_ERRS));
    // A zero tx register can only come from an upset; re-seeding keeps it alive.
    assign w_tx_init     = start | w_tx_zero;

    prbs_lfsr #(.ORDER(PRBS_ORDER)) u_tx_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_tx_init),
        .i_load     (1'b0),
        .i_load_bit (1'b0),
        .i_adv      (w_tx_stb),
        .o_next     (w_tx_next),
        .o_zero     (w_tx_zero)
    );

    prbs_lfsr #(.ORDER(PRBS_ORDER)) u_rx_pred (
        .clk        (clk),
        .rst        (rst),
        .i_init     (1'b0),
        .i_load     (w_seed_load),
        .i_load_bit (rx_bit),
        .i_adv      (w_pred_adv),
        .o_next     (w_pred_next),
        .o_zero     (w_pred_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_SEED;
        end else if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_SEED: begin
                    if (w_rx_stb && (r_seed_cnt == c_SEED_W'(PRBS_ORDER - 1))) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // An all-zero seed would match a stuck-at-0 channel forever.
                    if (w_rx_stb) begin
                        if (w_mm || w_pred_zero) begin
                            w_state_nxt = ST_SEED;
                        end else if (r_match == c_MATCH_W'(LOCK_BITS - 1)) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_rx_stb && w_loss) begin
                        w_state_nxt = ST_SEED;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_running   = (r_state != ST_IDLE);
        w_tx_stb    = start | (w_running & ~stop & (r_tmr == c_TMR_W'(SYMBOL_CYCLES - 1)));
        w_rx_stb    = w_running & ~start & ~stop & (r_tmr == c_TMR_W'(RX_SAMPLE_OFFSET));
        w_seed_load = w_rx_stb & (r_state == ST_SEED);
        w_pred_adv  = w_rx_stb & ((r_state == ST_CHECK) | (r_state == ST_LOCKED));
        w_lk_stb    = w_rx_stb & (r_state == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst || start || stop || (r_state == ST_IDLE)) begin
            r_tmr <= '0;
        end else if (r_tmr == c_TMR_W'(SYMBOL_CYCLES - 1)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + c_TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_bit    <= 1'b0;
            r_tx_en     <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_bit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_seed_cnt  <= '0;
            r_match     <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
        end else begin
            r_tx_en  <= w_tx_stb;
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_tx_stb) begin
                r_tx_bit <= w_tx_next ^ w_flip;
            end

            if (start) begin
                r_bit_cnt   <= '0;
                r_err_cnt   <= '0;
                r_lock_lost <= 1'b0;
            end else if (w_lk_stb) begin
                if (~&r_bit_cnt) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                if (w_mm && ~&r_err_cnt) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                if (w_loss) begin
                    r_lock_lost <= 1'b1;
                end
            end

            if (start || (r_state != ST_SEED)) begin
                r_seed_cnt <= '0;
            end else if (w_rx_stb && (r_seed_cnt != c_SEED_W'(PRBS_ORDER - 1))) begin
                r_seed_cnt <= r_seed_cnt + c_SEED_W'(1);
            end

            if (start || (r_state != ST_CHECK)) begin
                r_match <= '0;
            end else if (w_rx_stb && !w_mm && (r_match != c_MATCH_W'(LOCK_BITS - 1))) begin
                r_match <= r_match + c_MATCH_W'(1);
            end

            // Loss window is aligned to the moment lock was acquired.
            if (start || (r_state != ST_LOCKED) || (w_lk_stb && w_loss)) begin
                r_win_bits <= '0;
                r_win_err  <= '0;
            end else if (w_lk_stb) begin
                if (r_win_bits == c_MATCH_W'(LOCK_BITS - 1)) begin
                    r_win_bits <= '0;
                    r_win_err  <= '0;
                end else begin
                    r_win_bits <= r_win_bits + c_MATCH_W'(1);
                    r_win_err  <= w_win_err_nxt;
                end
            end
        end
    end

`ifdef BER_ERR_INJECT_EN
    logic r_inj_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_armed <= 1'b0;
        end else if (w_tx_stb) begin
            r_inj_armed <= ~r_inj_armed & inject_err;
        end else if (inject_err) begin
            r_inj_armed <= 1'b1;
        end
    end

    assign w_flip = r_inj_armed;
`else
    assign w_flip = 1'b0;
`endif

    assign tx_bit    = r_tx_bit;
    assign tx_bit_en = r_tx_en;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;
    assign bit_count = r_bit_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_ber_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_ber_tester
// Description : Self-checking bench for bpsk_ber_tester (wire, inverted and
//               delayed loopback; BER_ERR_INJECT_EN scenario when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_ber_tester;
    import bpsk_ber_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_bit, tx_bit_en, rx_bit, locked, lock_lost;
    logic [31:0] bit_count, err_count;
`ifdef BER_ERR_INJECT_EN
    logic        inject_err = 1'b0;
`endif

    logic        start_s = 1'b0;
    logic        tx_s, tx_en_s, locked_s, lost_s;
    logic [3:0]  bit_count_s, err_count_s;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          chan_mode = 0;
    logic [36:0] dly = '0;
    logic [6:0]  ref_lfsr = 7'h7F;
    bit          chk_tx = 1'b0;
    bit          inj_armed = 1'b0;
    logic        q_exp[$];

    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[35:0], tx_bit};

    always_comb begin
        case (chan_mode)
            0:       rx_bit = tx_bit;
            1:       rx_bit = ~tx_bit;
            default: rx_bit = dly[36];
        endcase
    end

    bpsk_ber_tester dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .tx_bit    (tx_bit),
        .tx_bit_en (tx_bit_en),
        .rx_bit    (rx_bit),
        .locked    (locked),
        .lock_lost (lock_lost),
        .bit_count (bit_count),
        .err_count (err_count)
`ifdef BER_ERR_INJECT_EN
        ,
        .inject_err(inject_err)
`endif
    );

    bpsk_ber_tester #(.SYMBOL_CYCLES(4), .RX_SAMPLE_OFFSET(1), .CNT_W(4)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .stop      (1'b0),
        .tx_bit    (tx_s),
        .tx_bit_en (tx_en_s),
        .rx_bit    (tx_s),
        .locked    (locked_s),
        .lock_lost (lost_s),
        .bit_count (bit_count_s),
        .err_count (err_count_s)
`ifdef BER_ERR_INJECT_EN
        ,
        .inject_err(1'b0)
`endif
    );

    // Reference x^7+x^6+1 generator feeding the expected-tx queue.
    task automatic push_ref();
        logic fb;
        fb = ref_lfsr[6] ^ ref_lfsr[5];
        ref_lfsr = {ref_lfsr[5:0], fb};
        q_exp.push_back(fb);
    endtask

    always @(negedge clk) begin
        if (chk_tx && tx_bit_en) begin
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL tx_queue: got strobe, required queued bit (queue empty)");
            end else begin
                logic exp_b;
                exp_b = q_exp.pop_front();
                inj_armed = 1'b0;
                if (tx_bit !== exp_b) begin
                    n_fail++;
                    $display("FAIL tx_bit: got %0b required %0b", tx_bit, exp_b);
                end
                push_ref();
            end
        end
    end

    task automatic do_start(input bit with_stop);
        @(negedge clk);
        #1;
        start = 1'b1;
        stop  = with_stop;
        q_exp.delete();
        ref_lfsr = 7'h7F;
        for (int i = 0; i < 16; i++) push_ref();
        chk_tx = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_locked(input int bound, input string name);
        int c;
        c = 0;
        while (locked !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: locked %0b after %0d cycles, required 1", name, locked, c);
        end
    endtask

    task automatic test_reset();
        bit seen_en;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests += 6;
        if (tx_bit !== 1'b0)     begin n_fail++; $display("FAIL rst_tx_bit: got %0b required 0", tx_bit); end
        if (tx_bit_en !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_en: got %0b required 0", tx_bit_en); end
        if (locked !== 1'b0)     begin n_fail++; $display("FAIL rst_locked: got %0b required 0", locked); end
        if (lock_lost !== 1'b0)  begin n_fail++; $display("FAIL rst_lost: got %0b required 0", lock_lost); end
        if (bit_count !== 32'd0) begin n_fail++; $display("FAIL rst_bits: got %0d required 0", bit_count); end
        if (err_count !== 32'd0) begin n_fail++; $display("FAIL rst_errs: got %0d required 0", err_count); end
        rst = 1'b0;
        seen_en = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_bit_en) seen_en = 1'b1;
        end
        n_tests++;
        if (seen_en) begin n_fail++; $display("FAIL idle_no_strobe: got strobe, required none"); end
    endtask

    task automatic test_lock_wire();
        int first;
        chan_mode = 0;
        first = -1;
        do_start(1'b0);
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_tests += 2;
                if (tx_bit_en !== 1'b1) begin n_fail++; $display("FAIL first_strobe: got %0b required 1", tx_bit_en); end
                if (dut.r_state !== ST_SEED) begin n_fail++; $display("FAIL state_seed: got %0d required %0d", dut.r_state, ST_SEED); end
            end
            if (locked === 1'b1) begin
                first = c;
                break;
            end
        end
        n_tests += 2;
        if (first != 772) begin n_fail++; $display("FAIL lock_time: got cycle %0d required 772", first); end
        if (bit_count !== 32'd0) begin n_fail++; $display("FAIL lock_bits0: got %0d required 0", bit_count); end
        repeat (19999) @(negedge clk);
        n_tests++;
        if (bit_count !== 32'd999) begin n_fail++; $display("FAIL bits_999: got %0d required 999", bit_count); end
        @(negedge clk);
        n_tests += 3;
        if (bit_count !== 32'd1000) begin n_fail++; $display("FAIL bits_1000: got %0d required 1000", bit_count); end
        if (err_count !== 32'd0)    begin n_fail++; $display("FAIL wire_errs: got %0d required 0", err_count); end
        if (locked !== 1'b1)        begin n_fail++; $display("FAIL wire_locked: got %0b required 1", locked); end
    endtask

    task automatic test_stop();
        bit seen_en;
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL stop_locked: got %0b required 0", locked); end
        seen_en = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx_bit_en) seen_en = 1'b1;
        end
        n_tests += 3;
        if (seen_en) begin n_fail++; $display("FAIL stop_strobe: got strobe, required none"); end
        if (bit_count !== 32'd1000) begin n_fail++; $display("FAIL stop_hold_bits: got %0d required 1000", bit_count); end
        if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL stop_state: got %0d required %0d", dut.r_state, ST_IDLE); end
        do_start(1'b1);
        @(negedge clk);
        n_tests += 3;
        if (tx_bit_en !== 1'b1) begin n_fail++; $display("FAIL start_wins_en: got %0b required 1", tx_bit_en); end
        if (dut.r_state !== ST_SEED) begin n_fail++; $display("FAIL start_wins_state: got %0d required %0d", dut.r_state, ST_SEED); end
        if (bit_count !== 32'd0) begin n_fail++; $display("FAIL start_clears: got %0d required 0", bit_count); end
    endtask

    task automatic test_inverted();
        bit seen_lock;
        chan_mode = 1;
        do_start(1'b0);
        seen_lock = 1'b0;
        repeat (200 * 20) begin
            @(negedge clk);
            if (locked) seen_lock = 1'b1;
        end
        n_tests += 2;
        if (seen_lock) begin n_fail++; $display("FAIL inv_locked: got lock, required none"); end
        if (bit_count !== 32'd0) begin n_fail++; $display("FAIL inv_bits: got %0d required 0", bit_count); end
    endtask

    task automatic test_loss();
        int c;
        chan_mode = 0;
        do_start(1'b0);
        wait_locked(1000, "loss_lock");
        c = 0;
        while (bit_count !== 32'd40 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chan_mode = 1;
        c = 0;
        while (lock_lost !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_tests += 5;
        if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL loss_flag: got %0b required 1", lock_lost); end
        if (locked !== 1'b0)    begin n_fail++; $display("FAIL loss_locked: got %0b required 0", locked); end
        if (bit_count !== 32'd48) begin n_fail++; $display("FAIL loss_bits: got %0d required 48", bit_count); end
        if (err_count !== 32'd8)  begin n_fail++; $display("FAIL loss_errs: got %0d required 8", err_count); end
        if (dut.r_state !== ST_SEED) begin n_fail++; $display("FAIL loss_state: got %0d required %0d", dut.r_state, ST_SEED); end
        repeat (60) @(negedge clk);
        n_tests += 2;
        if (bit_count !== 32'd48) begin n_fail++; $display("FAIL loss_hold_bits: got %0d required 48", bit_count); end
        if (err_count !== 32'd8)  begin n_fail++; $display("FAIL loss_hold_errs: got %0d required 8", err_count); end
        chan_mode = 0;
        wait_locked(1500, "relock");
        n_tests++;
        if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL lost_sticky: got %0b required 1", lock_lost); end
    endtask

    task automatic test_delay();
        chan_mode = 2;
        do_start(1'b0);
        wait_locked(4000, "delay_lock");
        repeat (4000) @(negedge clk);
        n_tests += 3;
        if (bit_count !== 32'd200) begin n_fail++; $display("FAIL delay_bits: got %0d required 200", bit_count); end
        if (err_count !== 32'd0)   begin n_fail++; $display("FAIL delay_errs: got %0d required 0", err_count); end
        if (locked !== 1'b1)       begin n_fail++; $display("FAIL delay_locked: got %0b required 1", locked); end
    endtask

`ifdef BER_ERR_INJECT_EN
    task automatic pulse_inject();
        inject_err = 1'b1;
        if (!inj_armed) begin
            inj_armed = 1'b1;
            q_exp[0] = ~q_exp[0];
        end
        @(posedge clk);
        #1;
        inject_err = 1'b0;
    endtask

    task automatic test_inject();
        int c;
        chan_mode = 0;
        do_start(1'b0);
        wait_locked(1000, "inj_lock");
        for (int i = 0; i < 5; i++) begin
            c = 0;
            while (tx_bit_en !== 1'b1 && c < 100) begin
                @(negedge clk);
                c++;
            end
            repeat (5) @(negedge clk);
            pulse_inject();
            if (i == 2) begin
                @(negedge clk);
                pulse_inject();
            end
            repeat (2000) @(negedge clk);
        end
        n_tests += 3;
        if (err_count !== 32'd5) begin n_fail++; $display("FAIL inj_errs: got %0d required 5", err_count); end
        if (locked !== 1'b1)     begin n_fail++; $display("FAIL inj_locked: got %0b required 1", locked); end
        if (lock_lost !== 1'b0)  begin n_fail++; $display("FAIL inj_lost: got %0b required 0", lock_lost); end
    endtask
`endif

    task automatic test_saturate();
        int c;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        c = 0;
        while (locked_s !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (locked_s !== 1'b1) begin n_fail++; $display("FAIL sat_lock: got %0b required 1", locked_s); end
        repeat (14 * 4) @(negedge clk);
        n_tests++;
        if (bit_count_s !== 4'd14) begin n_fail++; $display("FAIL sat_14: got %0d required 14", bit_count_s); end
        repeat (30 * 4) @(negedge clk);
        n_tests += 2;
        if (bit_count_s !== 4'd15) begin n_fail++; $display("FAIL sat_15: got %0d required 15", bit_count_s); end
        if (err_count_s !== 4'd0)  begin n_fail++; $display("FAIL sat_errs: got %0d required 0", err_count_s); end
    endtask

    task automatic test_rst_mid();
        chan_mode = 0;
        do_start(1'b0);
        wait_locked(1000, "rst_lock");
        repeat (110) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_tx = 1'b0;
        inj_armed = 1'b0;
        @(negedge clk);
        n_tests += 6;
        if (tx_bit_en !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_en: got %0b required 0", tx_bit_en); end
        if (tx_bit !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_tx: got %0b required 0", tx_bit); end
        if (locked !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_locked: got %0b required 0", locked); end
        if (lock_lost !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_lost: got %0b required 0", lock_lost); end
        if (bit_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_bits: got %0d required 0", bit_count); end
        if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_rst_state: got %0d required %0d", dut.r_state, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_lock_wire();
        test_stop();
        test_inverted();
        test_loss();
        test_delay();
`ifdef BER_ERR_INJECT_EN
        test_inject();
`endif
        test_saturate();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
